ps2_mouse_ctrl: RTL and testbench

Command sequencer and packet assembler sitting between the generic PS/2 link module and the Mac mouse/ADB logic. After reset it drives the link's byte-send handshake to initialise a PS/2 mouse (reset, BAT check, enable streaming). It then parses incoming stream bytes into movement packets. It is the sole owner of the link's oreq/obyte pair.

---
 rtl/ps2_pkg.sv | 68 ++++++
 rtl/ps2_mouse_pkt.sv | 110 +++++++++++
 rtl/ps2_mouse_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse controller: command and response
// byte codes, the controller state encoding and the initialisation ROM.
//
// Build option: define PS2_MOUSE_SCROLL_EN to select the wheel-mouse init
// sequence (sample-rate knock 200/100/80 followed by GET ID).
// ---------------------------------------------------------------------------
package ps2_pkg;

    // Host -> mouse commands
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_SETRATE = 8'hF3;
    localparam logic [7:0] CMD_GETID   = 8'hF2;

    // Mouse -> host responses
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] ID_STD     = 8'h00;
    localparam logic [7:0] ID_WHEEL   = 8'h03;

    // Index of the final byte of a stream packet (bi value)
    localparam logic [1:0] BI_LAST_STD   = 2'd2;
    localparam logic [1:0] BI_LAST_WHEEL = 2'd3;

    typedef enum logic [2:0] {
        ST_SEND,
        ST_WAIT_OACK,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_WAIT_XID,
        ST_STREAM
    } ctrl_state_t;

    localparam int STEP_W = 4;

`ifdef PS2_MOUSE_SCROLL_EN
    localparam int INIT_LEN = 9;
    localparam logic [STEP_W-1:0] STEP_GETID = 4'd7;

    function automatic logic [7:0] init_rom(input logic [STEP_W-1:0] step);
        case (step)
            4'd0:    init_rom = CMD_RESET;
            4'd1:    init_rom = CMD_SETRATE;
            4'd2:    init_rom = 8'hC8;      // 200 samples/s
            4'd3:    init_rom = CMD_SETRATE;
            4'd4:    init_rom = 8'h64;      // 100 samples/s
            4'd5:    init_rom = CMD_SETRATE;
            4'd6:    init_rom = 8'h50;      // 80 samples/s
            4'd7:    init_rom = CMD_GETID;
            default: init_rom = CMD_ENABLE;
        endcase
    endfunction
`else
    localparam int INIT_LEN = 2;

    function automatic logic [7:0] init_rom(input logic [STEP_W-1:0] step);
        case (step)
            4'd0:    init_rom = CMD_RESET;
            default: init_rom = CMD_ENABLE;
        endcase
    endfunction
`endif

endpackage

// File: rtl/ps2_mouse_pkt.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt
// Assembles streamed mouse bytes into movement packets.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr             holds the byte index at 0 (controller not streaming)
//   i_stb, i_byte     received byte strobe and value (already gated)
//   i_tmo             link inactivity strobe; drops a partial packet
//   i_n4              (PS2_MOUSE_SCROLL_EN only) 4-byte packets
//   o_pkt_valid       1-clk strobe, packet outputs updated this cycle
//   o_buttons         {middle, right, left}
//   o_dx, o_dy        9-bit two's complement movement, 0 on overflow
//   o_dz              (PS2_MOUSE_SCROLL_EN only) wheel movement
// ---------------------------------------------------------------------------
module ps2_mouse_pkt
    import ps2_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_stb,
    input  logic [7:0] i_byte,
    input  logic       i_tmo,
`ifdef PS2_MOUSE_SCROLL_EN
    input  logic       i_n4,
    output logic [3:0] o_dz,
`endif
    output logic       o_pkt_valid,
    output logic [2:0] o_buttons,
    output logic [8:0] o_dx,
    output logic [8:0] o_dy
);

    logic [1:0] r_bi;
    logic [2:0] r_btn;
    logic       r_xs, r_ys, r_xo, r_yo;
    logic [7:0] r_b1;
    logic       r_valid;
    logic [2:0] r_buttons;
    logic [8:0] r_dx, r_dy;
    logic [1:0] w_last;
    logic [7:0] w_ybyte;

`ifdef PS2_MOUSE_SCROLL_EN
    logic [7:0] r_b2;
    logic [3:0] r_dz;

    assign w_last  = i_n4 ? BI_LAST_WHEEL : BI_LAST_STD;
    // In 4-byte mode the Y byte was captured one byte earlier
    assign w_ybyte = (r_bi == BI_LAST_WHEEL) ? r_b2 : i_byte;
    assign o_dz    = r_dz;
`else
    assign w_last  = BI_LAST_STD;
    assign w_ybyte = i_byte;
`endif

    always_ff @(posedge i_clk) begin
        r_valid <= 1'b0;
        if (i_rst) begin
            r_bi      <= '0;
            r_buttons <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
`ifdef PS2_MOUSE_SCROLL_EN
            r_dz      <= '0;
`endif
        end else if (i_clr) begin
            r_bi <= '0;
        end else if (i_stb) begin
            if (r_bi == 2'd0) begin
                // Byte 0 always has bit3 set; anything else is resync noise
                if (i_byte[3]) begin
                    r_btn <= i_byte[2:0];
                    r_xs  <= i_byte[4];
                    r_ys  <= i_byte[5];
                    r_xo  <= i_byte[6];
                    r_yo  <= i_byte[7];
                    r_bi  <= 2'd1;
                end
            end else if (r_bi == 2'd1) begin
                r_b1 <= i_byte;
                r_bi <= 2'd2;
            end else if (r_bi == w_last) begin
                r_buttons <= r_btn;
                r_dx      <= r_xo ? 9'd0 : {r_xs, r_b1};
                r_dy      <= r_yo ? 9'd0 : {r_ys, w_ybyte};
`ifdef PS2_MOUSE_SCROLL_EN
                r_dz      <= (r_bi == BI_LAST_WHEEL) ? i_byte[3:0] : 4'd0;
`endif
                r_valid   <= 1'b1;
                r_bi      <= 2'd0;
            end else begin
`ifdef PS2_MOUSE_SCROLL_EN
                r_b2 <= i_byte;
`endif
                r_bi <= r_bi + 2'd1;
            end
        end else if (i_tmo) begin
            // Idle timeout at bi=0 is harmless; mid-packet it drops the partial
            r_bi <= '0;
        end
    end

    assign o_pkt_valid = r_valid;
    assign o_buttons   = r_buttons;
    assign o_dx        = r_dx;
    assign o_dy        = r_dy;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl
// Initialises a PS/2 mouse through the link's byte-send handshake, then
// hands received stream bytes to the packet assembler. Sole owner of the
// link's oreq/obyte pair.
//
// Ports:
//   sysclk, reset     clock, synchronous active-high reset
//   reinit            1-clk strobe, restart initialisation
//   oreq, obyte       send strobe and byte (obyte held until the next send)
//   oack              send complete strobe from the link
//   istrobe, ibyte    received byte strobe and value
//   timeout           link inactivity strobe
//   ready             high while streaming
//   pkt_valid         1-clk strobe, packet outputs updated
//   buttons, dx, dy   packet contents
//   dz                wheel movement (PS2_MOUSE_SCROLL_EN only)
//   err               1-clk strobe on every forced restart
//
// Build option: PS2_MOUSE_SCROLL_EN enables wheel-mouse detection and dz.
// ---------------------------------------------------------------------------
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int RETRY_MAX    = 3,
    parameter int BAT_TIMEOUTS = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       reinit,
    output logic       oreq,
    output logic [7:0] obyte,
    input  logic       oack,
    input  logic       istrobe,
    input  logic [7:0] ibyte,
    input  logic       timeout,
    output logic       ready,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
`ifdef PS2_MOUSE_SCROLL_EN
    output logic [3:0] dz,
`endif
    output logic       err
);

    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam int BW = $clog2(BAT_TIMEOUTS + 2);

    ctrl_state_t       r_state;
    logic [STEP_W-1:0] r_step;
    logic [RW-1:0]     r_retry;
    logic [BW-1:0]     r_batcnt;
    logic              r_oreq;
    logic [7:0]        r_obyte;
    logic              r_ready;
    logic              r_err;
    logic              w_fail;
    logic              w_pkt_stb;
    logic              w_pkt_clr;
`ifdef PS2_MOUSE_SCROLL_EN
    logic              r_n4;
`endif

    // Protocol failures that force a restart (reinit is handled separately)
    always_comb begin
        w_fail = 1'b0;
        case (r_state)
            ST_WAIT_OACK: w_fail = timeout;
            ST_WAIT_ACK: begin
                if (istrobe)
                    w_fail = (ibyte != RSP_ACK && ibyte != RSP_RESEND) ||
                             (ibyte == RSP_RESEND && r_retry == RW'(RETRY_MAX));
                else
                    w_fail = timeout;
            end
            ST_WAIT_BAT: begin
                if (istrobe)
                    w_fail = (ibyte != RSP_BAT);
                else
                    w_fail = timeout && (r_batcnt == BW'(BAT_TIMEOUTS));
            end
            ST_WAIT_ID: begin
                if (istrobe)
                    w_fail = (ibyte != ID_STD);
                else
                    w_fail = timeout;
            end
            ST_WAIT_XID: w_fail = !istrobe && timeout;
            default:     w_fail = 1'b0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        r_oreq <= 1'b0;
        r_err  <= 1'b0;
        if (reset) begin
            r_state  <= ST_SEND;
            r_step   <= '0;
            r_retry  <= '0;
            r_batcnt <= '0;
            r_obyte  <= '0;
            r_ready  <= 1'b0;
`ifdef PS2_MOUSE_SCROLL_EN
            r_n4     <= 1'b0;
`endif
        end else if (reinit || w_fail) begin
            r_state  <= ST_SEND;
            r_step   <= '0;
            r_retry  <= '0;
            r_batcnt <= '0;
            r_ready  <= 1'b0;
            r_err    <= 1'b1;
`ifdef PS2_MOUSE_SCROLL_EN
            r_n4     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_SEND: begin
                    r_oreq  <= 1'b1;
                    r_obyte <= init_rom(r_step);
                    r_state <= ST_WAIT_OACK;
                end
                ST_WAIT_OACK: begin
                    if (oack)
                        r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (istrobe) begin
                        if (ibyte == RSP_ACK) begin
                            r_retry <= '0;
                            if (r_step == '0) begin
                                r_batcnt <= '0;
                                r_state  <= ST_WAIT_BAT;
                            end
`ifdef PS2_MOUSE_SCROLL_EN
                            else if (r_step == STEP_GETID) begin
                                r_state <= ST_WAIT_XID;
                            end
`endif
                            else if (r_step == STEP_W'(INIT_LEN - 1)) begin
                                r_ready <= 1'b1;
                                r_state <= ST_STREAM;
                            end else begin
                                r_step  <= r_step + 4'd1;
                                r_state <= ST_SEND;
                            end
                        end else begin
                            // Only RSP_RESEND with retries left reaches here
                            r_retry <= r_retry + RW'(1);
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_WAIT_BAT: begin
                    if (istrobe)
                        r_state <= ST_WAIT_ID;
                    else if (timeout)
                        r_batcnt <= r_batcnt + BW'(1);
                end
                ST_WAIT_ID: begin
                    if (istrobe) begin
                        r_step  <= 4'd1;
                        r_state <= ST_SEND;
                    end
                end
`ifdef PS2_MOUSE_SCROLL_EN
                ST_WAIT_XID: begin
                    if (istrobe) begin
                        r_n4    <= (ibyte == ID_WHEEL);
                        r_step  <= r_step + 4'd1;
                        r_state <= ST_SEND;
                    end
                end
`endif
                ST_STREAM: begin
                end
                default: r_state <= ST_SEND;
            endcase
        end
    end

    // A reinit landing on a final packet byte must not deliver that packet
    assign w_pkt_stb = istrobe & r_ready & ~reinit;
    assign w_pkt_clr = reinit | ~r_ready;

    ps2_mouse_pkt u_pkt (
        .i_clk       (sysclk),
        .i_rst       (reset),
        .i_clr       (w_pkt_clr),
        .i_stb       (w_pkt_stb),
        .i_byte      (ibyte),
        .i_tmo       (timeout),
`ifdef PS2_MOUSE_SCROLL_EN
        .i_n4        (r_n4),
        .o_dz        (dz),
`endif
        .o_pkt_valid (pkt_valid),
        .o_buttons   (buttons),
        .o_dx        (dx),
        .o_dy        (dy)
    );

    assign oreq  = r_oreq;
    assign obyte = r_obyte;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
module tb_ps2_mouse_ctrl;

    localparam int RETRY_MAX    = 3;
    localparam int BAT_TIMEOUTS = 4;

`ifdef PS2_MOUSE_SCROLL_EN
    localparam int NCMD = 9;
    logic [7:0] cmd_seq [NCMD] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64,
                                   8'hF3, 8'h50, 8'hF2, 8'hF4};
`else
    localparam int NCMD = 2;
    logic [7:0] cmd_seq [NCMD] = '{8'hFF, 8'hF4};
`endif

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [3:0] dz;
    } pkt_t;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       reinit = 1'b0;
    logic       oreq;
    logic [7:0] obyte;
    logic       oack = 1'b0;
    logic       istrobe = 1'b0;
    logic [7:0] ibyte = 8'h00;
    logic       timeout = 1'b0;
    logic       ready;
    logic       pkt_valid;
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] w_dz;
    logic       err;

    int checks = 0;
    int passes = 0;

    logic [7:0] q_send [$];
    pkt_t       q_pkt  [$];
    bit         q_err  [$];

    // Reference model state: bytes of the packet being collected
    logic [7:0] m_buf [$];
    int         m_n = 3;

    ps2_mouse_ctrl #(
        .RETRY_MAX    (RETRY_MAX),
        .BAT_TIMEOUTS (BAT_TIMEOUTS)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .reinit    (reinit),
        .oreq      (oreq),
        .obyte     (obyte),
        .oack      (oack),
        .istrobe   (istrobe),
        .ibyte     (ibyte),
        .timeout   (timeout),
        .ready     (ready),
        .pkt_valid (pkt_valid),
        .buttons   (buttons),
        .dx        (dx),
        .dy        (dy),
`ifdef PS2_MOUSE_SCROLL_EN
        .dz        (w_dz),
`endif
        .err       (err)
    );

`ifndef PS2_MOUSE_SCROLL_EN
    assign w_dz = 4'd0;
`endif

    always #5 sysclk = ~sysclk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h want=%h", nm, got, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge sysclk) begin
        if (oreq) begin
            check("oreq_expected", {31'd0, oreq}, {31'd0, q_send.size() > 0});
            if (q_send.size() > 0) check("obyte", {24'd0, obyte}, {24'd0, q_send.pop_front()});
        end
        if (pkt_valid) begin
            check("pkt_expected", {31'd0, pkt_valid}, {31'd0, q_pkt.size() > 0});
            if (q_pkt.size() > 0) check("pkt", {7'd0, buttons, dx, dy, w_dz}, {7'd0, q_pkt.pop_front()});
        end
        if (err) begin
            check("err_expected", {31'd0, err}, {31'd0, q_err.size() > 0});
            if (q_err.size() > 0) void'(q_err.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    // Behavioural packet model: collect bytes, skip non-sync first bytes
    task automatic model_byte(input logic [7:0] b);
        pkt_t p;
        int   x, y;
        if (m_buf.size() == 0 && !b[3]) return;
        m_buf.push_back(b);
        if (m_buf.size() == m_n) begin
            x = m_buf[0][6] ? 0 : int'(m_buf[1]) - (m_buf[0][4] ? 256 : 0);
            y = m_buf[0][7] ? 0 : int'(m_buf[2]) - (m_buf[0][5] ? 256 : 0);
            p.btn = m_buf[0][2:0];
            p.dx  = 9'(x);
            p.dy  = 9'(y);
            p.dz  = (m_n == 4) ? m_buf[3][3:0] : 4'd0;
            q_pkt.push_back(p);
            m_buf.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic rsp(input logic [7:0] b);
        @(posedge sysclk); #1 istrobe = 1'b1; ibyte = b;
        @(posedge sysclk); #1 istrobe = 1'b0;
        idle(1);
    endtask

    task automatic sbyte(input logic [7:0] b);
        model_byte(b);
        rsp(b);
    endtask

    task automatic pulse_tmo();
        @(posedge sysclk); #1 timeout = 1'b1;
        @(posedge sysclk); #1 timeout = 1'b0;
    endtask

    task automatic stmo();
        m_buf.delete();
        pulse_tmo();
    endtask

    task automatic pulse_reinit();
        @(posedge sysclk); #1 reinit = 1'b1;
        @(posedge sysclk); #1 reinit = 1'b0;
        m_buf.delete();
        m_n = 3;
    endtask

    task automatic push_send(input logic [7:0] b);
        q_send.push_back(b);
    endtask

    task automatic wait_oreq();
        int n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (oreq !== 1'b1 && n < 100);
        if (oreq !== 1'b1) check("oreq_wait", {31'd0, oreq}, 32'd1);
    endtask

    task automatic take_send();
        wait_oreq();
        idle(1);
        @(posedge sysclk); #1 oack = 1'b1;
        @(posedge sysclk); #1 oack = 1'b0;
        idle(1);
    endtask

    // All init commands except the final enable
    task automatic init_prefix(input logic [7:0] id);
        for (int i = 0; i < NCMD - 1; i++) begin
            push_send(cmd_seq[i]);
            take_send();
            rsp(8'hFA);
            if (cmd_seq[i] == 8'hFF) begin
                rsp(8'hAA);
                rsp(8'h00);
            end
            if (cmd_seq[i] == 8'hF2) begin
                rsp(id);
                m_n = (id == 8'h03) ? 4 : 3;
            end
        end
    endtask

    task automatic finish_init(input string nm);
        push_send(8'hF4);
        take_send();
        rsp(8'hFA);
        idle(2);
        check(nm, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        idle(3);
        @(negedge sysclk);
        check("rst_oreq", {31'd0, oreq}, 32'd0);
        check("rst_obyte", {24'd0, obyte}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_buttons", {29'd0, buttons}, 32'd0);
        check("rst_dx", {23'd0, dx}, 32'd0);
        check("rst_dy", {23'd0, dy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge sysclk); #1 reset = 1'b0;

        // Clean initialisation
        init_prefix(8'h00);
        finish_init("ready_clean");

        // Fixed packets, resync, overflow, partial drop
        sbyte(8'h29); sbyte(8'h05); sbyte(8'hF0);
        sbyte(8'h00); sbyte(8'hC8); sbyte(8'h10); sbyte(8'h20);
        sbyte(8'h08); sbyte(8'h01); stmo();
        sbyte(8'h08); sbyte(8'h02); sbyte(8'h03);
        stmo();   // idle timeout at bi=0

        // Randomised stream
        for (int i = 0; i < 80; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) == 0) begin
                stmo();
            end else begin
                b = 8'($urandom);
                if (m_buf.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
                sbyte(b);
            end
            idle($urandom_range(0, 2));
        end
        idle(3);
        check("ready_stream", {31'd0, ready}, 32'd1);

        // reinit coinciding with the final packet byte
        stmo();
        sbyte(8'h08); sbyte(8'h01);
        q_err.push_back(1'b1);
        @(posedge sysclk); #1 istrobe = 1'b1; ibyte = 8'h02; reinit = 1'b1;
        @(posedge sysclk); #1 istrobe = 1'b0; reinit = 1'b0;
        m_buf.delete();
        check("ready_drop", {31'd0, ready}, 32'd0);

        // Two resends of the enable, then acknowledged
        init_prefix(8'h00);
        push_send(8'hF4); take_send();
        push_send(8'hF4); rsp(8'hFE); take_send();
        push_send(8'hF4); rsp(8'hFE); take_send();
        rsp(8'hFA);
        idle(2);
        check("ready_resend", {31'd0, ready}, 32'd1);

        // Resend limit exceeded
        q_err.push_back(1'b1);
        pulse_reinit();
        init_prefix(8'h00);
        push_send(8'hF4); take_send();
        for (int i = 0; i <= RETRY_MAX; i++) begin
            if (i < RETRY_MAX) push_send(8'hF4);
            else q_err.push_back(1'b1);
            rsp(8'hFE);
            if (i < RETRY_MAX) take_send();
        end
        check("ready_retry_fail", {31'd0, ready}, 32'd0);
        init_prefix(8'h00);
        finish_init("ready_after_retry");

        // Bad BAT byte
        q_err.push_back(1'b1);
        pulse_reinit();
        push_send(8'hFF); take_send(); rsp(8'hFA);
        q_err.push_back(1'b1);
        rsp(8'h55);
        init_prefix(8'h00);
        finish_init("ready_after_bat");

        // BAT timeouts
        q_err.push_back(1'b1);
        pulse_reinit();
        push_send(8'hFF); take_send(); rsp(8'hFA);
        for (int i = 0; i < BAT_TIMEOUTS; i++) begin
            pulse_tmo();
            idle(1);
        end
        q_err.push_back(1'b1);
        pulse_tmo();
        init_prefix(8'h00);
        finish_init("ready_after_tmo");

        // Reset while waiting for oack
        sbyte(8'h1B); sbyte(8'h80); sbyte(8'h7F);
        q_err.push_back(1'b1);
        pulse_reinit();
        push_send(8'hFF);
        wait_oreq();
        @(posedge sysclk); #1 reset = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check("rst2_obyte", {24'd0, obyte}, 32'd0);
        check("rst2_ready", {31'd0, ready}, 32'd0);
        check("rst2_buttons", {29'd0, buttons}, 32'd0);
        check("rst2_dx", {23'd0, dx}, 32'd0);
        check("rst2_dy", {23'd0, dy}, 32'd0);
        check("rst2_oreq", {31'd0, oreq}, 32'd0);
        @(posedge sysclk); #1 reset = 1'b0;
        m_buf.delete();
        m_n = 3;
        init_prefix(8'h00);
        finish_init("ready_after_reset");
        sbyte(8'h0A); sbyte(8'hFF); sbyte(8'h01);

`ifdef PS2_MOUSE_SCROLL_EN
        // Wheel mouse: 4-byte packets with dz
        q_err.push_back(1'b1);
        pulse_reinit();
        init_prefix(8'h03);
        finish_init("ready_wheel");
        sbyte(8'h08); sbyte(8'h00); sbyte(8'h00); sbyte(8'h0F);
        sbyte(8'h39); sbyte(8'h10); sbyte(8'hE0); sbyte(8'h02);
`endif

        idle(10);
        check("q_send_empty", q_send.size(), 32'd0);
        check("q_pkt_empty", q_pkt.size(), 32'd0);
        check("q_err_empty", q_err.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
